// File: rtl/san_pkg.sv
// Shared definitions for the SAN interrupt coalescer:
// register word map, FSM encoding and CTRL/STATUS bit positions.
package san_pkg;

  localparam logic [2:0] REG_CTRL    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_HOLDOFF = 3'd3;
  localparam logic [2:0] REG_TSTAMP  = 3'd4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_TH_LO = 8;
  localparam int CTRL_TH_HI = 15;

  localparam int STAT_OVF   = 16;
  localparam int STAT_IRQ   = 17;
  localparam int STAT_ST_LO = 18;
  localparam int STAT_ST_HI = 19;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_ASSERT = 2'd2
  } state_t;

endpackage

// File: rtl/san_irq_regs.sv
// Register file for words 1..4: CTRL, STATUS/ACK, HOLDOFF, TSTAMP,
// plus the combinational read mux.
module san_irq_regs
  import san_pkg::*;
#(
  parameter int PEND_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wren,
  input  logic [2:0]        awaddr,
  input  logic [31:0]       wdata,
  input  logic [2:0]        araddr,
  input  logic              cap,
  input  logic [31:0]       count_san,
  input  logic [PEND_W-1:0] pend,
  input  logic              ovf,
  input  logic              irq,
  input  logic [1:0]        state,
  output logic              irq_en,
  output logic [7:0]        thresh,
  output logic [31:0]       holdoff,
  output logic              ack,
  output logic [31:0]       rdata
);

  logic [31:0] tstamp;
  logic [31:0] status;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en  <= 1'b0;
      thresh  <= 8'd0;
      holdoff <= 32'd0;
      tstamp  <= 32'd0;
    end else begin
      if (wren && awaddr == REG_CTRL) begin
        irq_en <= wdata[CTRL_EN];
        thresh <= wdata[CTRL_TH_HI:CTRL_TH_LO];
      end
      if (wren && awaddr == REG_HOLDOFF)
        holdoff <= wdata;
      if (cap)
        tstamp <= count_san;
    end
  end

  assign ack = wren && (awaddr == REG_STATUS) && wdata[0];

  always_comb begin
    status = 32'd0;
    status[PEND_W-1:0] = pend;
    status[STAT_OVF] = ovf;
    status[STAT_IRQ] = irq;
    status[STAT_ST_HI:STAT_ST_LO] = state;
  end

  always_comb begin
    rdata = 32'd0;
    case (araddr)
      REG_CTRL:    rdata = {16'd0, thresh, 7'd0, irq_en};
      REG_STATUS:  rdata = status;
      REG_HOLDOFF: rdata = holdoff;
      REG_TSTAMP:  rdata = tstamp;
      default:     rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/san_irq_coalesce.sv
// Coalesces tick-counter event pulses into a level interrupt, raised
// on a pending-count threshold or a holdoff timeout, cleared by ACK.
module san_irq_coalesce
  import san_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int PEND_W             = 8
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic                          slv_reg_wren,
  input  logic [2:0]                    axi_awaddr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [2:0]                    axi_araddr,
  input  logic                          EXT_IRQ,
  input  logic [31:0]                   COUNT_SAN,
  output logic                          IRQ_OUT,
  output logic [31:0]                   RDATA
);

  localparam logic [PEND_W-1:0] PMAX = '1;
  localparam logic [PEND_W-1:0] PONE = PEND_W'(1);

  state_t            state, state_nx;
  logic [PEND_W-1:0] pend, pend_nx, pend_up;
  logic              ovf, ovf_nx, ovf_up;
  logic [31:0]       timer, timer_nx;
  logic              cap, first;
  logic              irq_en, ack;
  logic [7:0]        thresh, thr_eff;
  logic [31:0]       holdoff;

  san_irq_regs #(.PEND_W(PEND_W)) u_regs (
    .clk       (S_AXI_ACLK),
    .rst       (S_AXI_ARESET),
    .wren      (slv_reg_wren),
    .awaddr    (axi_awaddr),
    .wdata     (S_AXI_WDATA),
    .araddr    (axi_araddr),
    .cap       (cap),
    .count_san (COUNT_SAN),
    .pend      (pend),
    .ovf       (ovf),
    .irq       (IRQ_OUT),
    .state     (state),
    .irq_en    (irq_en),
    .thresh    (thresh),
    .holdoff   (holdoff),
    .ack       (ack),
    .rdata     (RDATA)
  );

  assign thr_eff = (thresh == 8'd0) ? 8'd1 : thresh;
  // An ACK in the same cycle as an event restarts a batch, not drops it.
  assign first = EXT_IRQ && (state == ST_IDLE || ack);

  always_comb begin
    pend_up = pend;
    ovf_up  = ovf;
    if (EXT_IRQ) begin
      if (pend == PMAX) ovf_up = 1'b1;
      else              pend_up = pend + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    pend_nx  = pend;
    ovf_nx   = ovf;
    timer_nx = timer;
    cap      = 1'b0;
    if (!irq_en) begin
      state_nx = ST_IDLE;
      pend_nx  = '0;
      ovf_nx   = 1'b0;
      timer_nx = 32'd0;
    end else if (first) begin
      state_nx = (thr_eff <= 8'd1) ? ST_ASSERT : ST_ACCUM;
      pend_nx  = PONE;
      ovf_nx   = 1'b0;
      timer_nx = 32'd0;
      cap      = 1'b1;
    end else if (ack && state != ST_IDLE) begin
      state_nx = ST_IDLE;
      pend_nx  = '0;
      ovf_nx   = 1'b0;
      timer_nx = 32'd0;
    end else if (state == ST_ACCUM) begin
      timer_nx = timer + 32'd1;
      pend_nx  = pend_up;
      ovf_nx   = ovf_up;
      if (32'(pend_up) >= 32'(thr_eff) ||
          (holdoff != 32'd0 && timer == holdoff - 32'd1))
        state_nx = ST_ASSERT;
    end else if (state == ST_ASSERT) begin
      pend_nx = pend_up;
      ovf_nx  = ovf_up;
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state   <= ST_IDLE;
      pend    <= '0;
      ovf     <= 1'b0;
      timer   <= 32'd0;
      IRQ_OUT <= 1'b0;
    end else begin
      state   <= state_nx;
      pend    <= pend_nx;
      ovf     <= ovf_nx;
      timer   <= timer_nx;
      IRQ_OUT <= (state == ST_ASSERT);
    end
  end

endmodule

// File: tb/tb_san_irq_coalesce.sv
// Directed bench for san_irq_coalesce: threshold, timeout, saturation,
// ACK/event collision, disable and asynchronous reset.
module tb_san_irq_coalesce;

  logic        clk = 1'b0;
  logic        rst;
  logic        wren;
  logic [2:0]  awaddr;
  logic [31:0] wdata;
  logic [2:0]  araddr;
  logic        ext;
  logic [31:0] count_san;
  logic        irq;
  logic [31:0] rdata;

  int n_pass = 0;
  int n_total = 0;

  san_irq_coalesce #(.C_S_AXI_DATA_WIDTH(32), .PEND_W(8)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .slv_reg_wren (wren),
    .axi_awaddr   (awaddr),
    .S_AXI_WDATA  (wdata),
    .axi_araddr   (araddr),
    .EXT_IRQ      (ext),
    .COUNT_SAN    (count_san),
    .IRQ_OUT      (irq),
    .RDATA        (rdata)
  );

  always #5 clk = ~clk;

  // STATUS word: pend | ovf<<16 | irq<<17 | state<<18
  function automatic logic [31:0] st(int pend, int ovf, int irq_v, int s);
    return 32'(pend) | (32'(ovf) << 16) | (32'(irq_v) << 17) | (32'(s) << 18);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_reg(string tag, logic [2:0] a, logic [31:0] exp);
    araddr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic chk_irq(string tag, logic exp);
    #1;
    chk(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d);
    wren = 1'b1;
    awaddr = a;
    wdata = d;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic pulse(logic [31:0] cs);
    ext = 1'b1;
    count_san = cs;
    @(negedge clk);
    ext = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wren = 1'b0;
    awaddr = 3'd0;
    wdata = 32'd0;
    araddr = 3'd0;
    ext = 1'b0;
    count_san = 32'd0;
    tick(2);
    chk_irq("reset_irq", 1'b0);
    chk_reg("reset_ctrl", 3'd1, 32'd0);
    chk_reg("reset_status", 3'd2, 32'd0);
    chk_reg("reset_holdoff", 3'd3, 32'd0);
    chk_reg("reset_tstamp", 3'd4, 32'd0);
    rst = 1'b0;
    tick(1);

    // 1: thresh=1
    wr(3'd1, 32'h0000_0101);
    wr(3'd3, 32'd0);
    chk_reg("t1_ctrl", 3'd1, 32'h0000_0101);
    pulse(32'd1000000);
    tick(1);
    chk_irq("t1_irq_rise", 1'b1);
    chk_reg("t1_status", 3'd2, st(1, 0, 1, 2));
    chk_reg("t1_tstamp", 3'd4, 32'd1000000);
    wr(3'd4, 32'hDEAD_BEEF);
    chk_reg("t1_tstamp_ro", 3'd4, 32'd1000000);
    chk_reg("unmapped_w0", 3'd0, 32'd0);
    chk_reg("unmapped_w5", 3'd5, 32'd0);
    wr(3'd2, 32'd1);
    tick(1);
    chk_irq("t1_ack_irq", 1'b0);
    chk_reg("t1_ack_status", 3'd2, 32'd0);

    // 2: thresh=4, pulses 10 cycles apart
    wr(3'd1, 32'h0000_0401);
    for (int i = 0; i < 3; i++) begin
      pulse(32'(100 + i));
      tick(9);
    end
    chk_irq("t2_irq_3", 1'b0);
    chk_reg("t2_status_3", 3'd2, st(3, 0, 0, 1));
    pulse(32'd103);
    tick(1);
    chk_irq("t2_irq_4", 1'b1);
    chk_reg("t2_status_4", 3'd2, st(4, 0, 1, 2));
    chk_reg("t2_tstamp", 3'd4, 32'd100);
    wr(3'd2, 32'd0);
    tick(1);
    chk_reg("t2_noack", 3'd2, st(4, 0, 1, 2));
    wr(3'd2, 32'd1);
    tick(1);
    chk_irq("t2_ack_irq", 1'b0);
    chk_reg("t2_ack_status", 3'd2, 32'd0);

    // 3: holdoff timeout
    wr(3'd1, 32'h0000_0801);
    wr(3'd3, 32'd50);
    pulse(32'd5555);
    tick(49);
    chk_reg("t3_accum", 3'd2, st(1, 0, 0, 1));
    tick(1);
    chk_reg("t3_timeout", 3'd2, st(1, 0, 0, 2));
    chk_irq("t3_irq_50", 1'b0);
    tick(1);
    chk_irq("t3_irq_51", 1'b1);
    wr(3'd2, 32'd1);
    wr(3'd3, 32'd0);

    // 4: saturation
    wr(3'd1, 32'h0000_FF01);
    for (int i = 0; i < 254; i++) begin
      pulse(32'(7000 + i));
      tick(1);
    end
    chk_reg("t4_pend254", 3'd2, st(254, 0, 0, 1));
    for (int i = 254; i < 257; i++) begin
      pulse(32'(7000 + i));
      tick(1);
    end
    chk_reg("t4_sat", 3'd2, st(255, 1, 1, 2));
    chk_reg("t4_tstamp", 3'd4, 32'd7000);
    wr(3'd2, 32'd1);
    tick(1);
    chk_reg("t4_ack", 3'd2, 32'd0);

    // 5: thresh=0 acts as 1, then ACK+event collision
    wr(3'd1, 32'h0000_0001);
    pulse(32'd111);
    tick(1);
    chk_reg("t5_thr0", 3'd2, st(1, 0, 1, 2));
    wr(3'd1, 32'h0000_0101);
    pulse(32'd112);
    tick(1);
    chk_reg("t5_pend2", 3'd2, st(2, 0, 1, 2));
    wren = 1'b1;
    awaddr = 3'd2;
    wdata = 32'd1;
    ext = 1'b1;
    count_san = 32'd222;
    @(negedge clk);
    wren = 1'b0;
    ext = 1'b0;
    chk_reg("t5_collide", 3'd2, st(1, 0, 1, 2));
    chk_reg("t5_tstamp", 3'd4, 32'd222);
    tick(1);
    chk_irq("t5_irq", 1'b1);

    // 6: disable, ignored event, reset mid-ACCUM
    wr(3'd1, 32'h0000_0100);
    tick(2);
    chk_irq("t6_dis_irq", 1'b0);
    chk_reg("t6_dis_status", 3'd2, 32'd0);
    pulse(32'd333);
    tick(2);
    chk_irq("t6_ign_irq", 1'b0);
    chk_reg("t6_ign_status", 3'd2, 32'd0);
    chk_reg("t6_ign_tstamp", 3'd4, 32'd222);
    wr(3'd1, 32'h0000_0801);
    wr(3'd3, 32'd100);
    pulse(32'd444);
    tick(3);
    chk_reg("t6_accum", 3'd2, st(1, 0, 0, 1));
    rst = 1'b1;
    #1;
    chk_reg("t6_rst_status", 3'd2, 32'd0);
    chk_reg("t6_rst_ctrl", 3'd1, 32'd0);
    chk_reg("t6_rst_holdoff", 3'd3, 32'd0);
    chk_reg("t6_rst_tstamp", 3'd4, 32'd0);
    chk_irq("t6_rst_irq", 1'b0);
    tick(1);
    rst = 1'b0;
    tick(5);
    chk_irq("t6_post_irq", 1'b0);
    chk_reg("t6_post_status", 3'd2, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
